// File: rtl/a2d_pkg.sv
// Shared definitions for the ADC128S conversion scheduler: channel map,
// scheduler state encoding and the SPI command builder.
package a2d_pkg;

    // ADC128S channel numbers for the four sweep slots.
    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    // Last transaction index of a sweep (T4, the dummy resend of slot 0).
    localparam logic [2:0] IDX_LAST = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    // SPI command word: channel select lives in bits [13:11].
    function automatic logic [15:0] build_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_sched.sv
// Round-robin ADC128S sweep scheduler. Each request drives the SPI master
// through five pipelined transactions (T0..T4), collects the four channel
// results and publishes them with a one-cycle round_vld strobe.
module a2d_sched
    import a2d_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        round_vld,
    output logic        busy,
    output logic        err
);

    localparam int unsigned     CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               wrt_q, wrt_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [3:0][11:0]   res_q, res_d;
    logic               rv_q, rv_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [CW-1:0]      cnt_inc;
    logic [1:0]         slot;
    logic [2:0]         ch;
    logic               load_cmd;
    logic               rd_hi_unused;

    // Upper response nibble carries no conversion data.
    assign rd_hi_unused = ^rd_data[15:12];

    // Next-state, result capture and strobe generation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        wrt_d    = 1'b0;
        cmd_d    = cmd_q;
        res_d    = res_q;
        rv_d     = 1'b0;
        err_d    = 1'b0;
        load_cmd = 1'b0;
        ch       = CH_LFT;
        cnt_inc  = cnt_q + CW'(1);
        slot     = 2'(idx_q - 3'd1);

        case (state_q)
            IDLE: begin
                if (nxt || pend_q) begin
                    idx_d    = '0;
                    pend_d   = 1'b0;
                    wrt_d    = 1'b1;
                    load_cmd = 1'b1;
                    state_d  = ISSUE;
                end
            end
            // ISSUE entered from IDLE already carries wrt; entered from WAIT it
            // spends one quiet cycle first, so wrt_q tells the two apart.
            ISSUE: begin
                if (nxt) pend_d = 1'b1;
                cnt_d = '0;
                if (wrt_q) state_d = WAIT;
                else       wrt_d   = 1'b1;
            end
            WAIT: begin
                if (nxt) pend_d = 1'b1;
                if (done) begin
                    if (idx_q != 3'd0) res_d[slot] = rd_data[11:0];
                    if (idx_q == IDX_LAST) begin
                        rv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        load_cmd = 1'b1;
                        state_d  = ISSUE;
                    end
                end else if (cnt_inc == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_cmd) begin
            case (idx_d)
                3'd0:    ch = CH_LFT;
                3'd1:    ch = CH_RGHT;
                3'd2:    ch = CH_STEER;
                3'd3:    ch = CH_BATT;
                default: ch = CH_LFT;
            endcase
            cmd_d = build_cmd(ch);
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            wrt_q   <= 1'b0;
            cmd_q   <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];
    assign round_vld = rv_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
